// File: rtl/ram_sync.sv
// ram_sync: single-port synchronous RAM with registered, write-through read data
module ram_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // storage and read register; reset clears every word, a write also drives data_out
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            data_out <= '0;
        end else begin
            if (we) mem[addr] <= data_in;
            data_out <= we ? data_in : mem[addr];
        end
    // a write to an unknown address would corrupt an unpredictable word
    addr_known: assert property (@(posedge clk) disable iff (rst) !(we && $isunknown(addr)));
endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: randomized scoreboard bench for ram_sync against an array model
module tb_ram_sync;
    logic       clk = 0;
    logic       rst = 0;
    logic       we = 0;
    logic [3:0] addr = 0;
    logic [7:0] data_in = 0;
    logic [7:0] data_out;
    logic [7:0] model [16];
    logic [7:0] q [$];
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    ram_sync dut (.clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in), .data_out(data_out));
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 8'd0;
    endtask
    task automatic op(input logic w, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        we = w;
        addr = a;
        data_in = d;
        q.push_back(w ? d : model[a]);
        if (w) model[a] = d;
        @(posedge clk);
        #2;
    endtask
    task automatic mid_reset(input string name);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check(name, data_out, 8'd0);
        clear_model();
    endtask
    // monitor: every edge that follows an issued operation is compared against the queue
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) check("data_out", data_out, q.pop_front());
    end
    initial begin
        logic [7:0] wdat [5];
        logic [7:0] held;
        wdat[0] = 8'd55; wdat[1] = 8'd99; wdat[2] = 8'd150; wdat[3] = 8'd200; wdat[4] = 8'd77;
        mid_reset("reset_async");
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 16; i++) op(1'b0, 4'(i), 8'd0);
        for (int i = 0; i < 5; i++) op(1'b1, 4'(i), wdat[i]);
        for (int i = 0; i < 5; i++) op(1'b0, 4'(i), 8'd0);
        op(1'b1, 4'd15, 8'hAA);
        op(1'b1, 4'd15, 8'h11);
        op(1'b0, 4'd15, 8'd0);
        op(1'b0, 4'd14, 8'd0);
        op(1'b0, 4'd3, 8'd0);
        held = data_out;
        addr = 4'd9;
        #1;
        check("hold_addr_toggle", data_out, held);
        addr = 4'd4;
        #1;
        check("hold_addr_toggle2", data_out, held);
        op(1'b0, 4'd4, 8'd0);
        mid_reset("reset_after_writes");
        we = 1;
        addr = 4'd2;
        data_in = 8'd33;
        @(posedge clk);
        #1;
        check("write_during_reset", data_out, 8'd0);
        @(negedge clk);
        we = 0;
        rst = 0;
        for (int i = 0; i < 5; i++) op(1'b0, 4'(i), 8'd0);
        for (int n = 0; n < 400; n++)
            op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        for (int i = 0; i < 16; i++) op(1'b0, 4'(i), 8'd0);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
